// File: rtl/ft60x_axi_cmd_pkg.sv
// FT60x host command engine: shared constants,
// FSM encoding and status word builder.
package ft60x_axi_cmd_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h10;
  localparam logic [7:0] CMD_READ  = 8'h11;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  localparam int ST_CMD_LSB = 0;
  localparam int ST_ERR_BIT = 8;
  localparam int ST_CNT_LSB = 16;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR    = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_RD_REQ  = 3'd5,
    S_RD_RESP = 3'd6,
    S_STATUS  = 3'd7
  } state_t;

  function automatic logic [31:0] status_word(
    input logic [7:0]  cmd,
    input logic        err,
    input logic [15:0] cnt
  );
    logic [31:0] w;
    w = '0;
    w[ST_CMD_LSB +: 8]  = cmd;
    w[ST_ERR_BIT]       = err;
    w[ST_CNT_LSB +: 16] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/ft60x_axi_cmd.sv
// FT60x host command engine: decodes host write/read
// commands into single-beat AXI4-Lite transactions.
module ft60x_axi_cmd
  import ft60x_axi_cmd_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_valid_i,
  input  logic [31:0] inport_data_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  input  logic        outport_accept_i,
  output logic        axi_awvalid_o,
  output logic [31:0] axi_awaddr_o,
  input  logic        axi_awready_i,
  output logic        axi_wvalid_o,
  output logic [31:0] axi_wdata_o,
  output logic [3:0]  axi_wstrb_o,
  input  logic        axi_wready_i,
  input  logic        axi_bvalid_i,
  input  logic [1:0]  axi_bresp_i,
  output logic        axi_bready_o,
  output logic        axi_arvalid_o,
  output logic [31:0] axi_araddr_o,
  input  logic        axi_arready_i,
  input  logic        axi_rvalid_i,
  input  logic [31:0] axi_rdata_i,
  input  logic [1:0]  axi_rresp_i,
  output logic        axi_rready_o
);

  state_t      state_q, state_d;
  logic [7:0]  cmd_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] out_data_q;
  logic        err_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        out_valid_q;
  logic        accept_q;
  logic        st_sent_q;

  logic in_fire;
  logic out_free;
  logic r_fire;
  logic last;
  logic hdr_ok;
  logic b_err;
  logic r_err;

  assign in_fire  = inport_valid_i & accept_q;
  assign out_free = ~out_valid_q | outport_accept_i;
  assign r_fire   = axi_rvalid_i & axi_rready_o;
  assign last     = (cnt_q + 16'd1) == len_q;
  assign b_err    = axi_bresp_i != AXI_OKAY;
  assign r_err    = axi_rresp_i != AXI_OKAY;
  assign hdr_ok   = (inport_data_i[7:0] == CMD_WRITE)
                  | (inport_data_i[7:0] == CMD_READ);

  assign inport_accept_o = accept_q;
  assign outport_valid_o = out_valid_q;
  assign outport_data_o  = out_data_q;
  assign axi_awvalid_o   = awvalid_q;
  assign axi_awaddr_o    = addr_q;
  assign axi_wvalid_o    = wvalid_q;
  assign axi_wdata_o     = wdata_q;
  assign axi_wstrb_o     = 4'hF;
  assign axi_bready_o    = state_q == S_WR_RESP;
  assign axi_arvalid_o   = state_q == S_RD_REQ;
  assign axi_araddr_o    = addr_q;
  assign axi_rready_o    = (state_q == S_RD_RESP) & out_free;

  // Next-state decode of the command sequencer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_fire && hdr_ok) state_d = S_ADDR;
      end
      S_ADDR: begin
        if (in_fire) begin
          if (len_q == 16'd0)         state_d = S_STATUS;
          else if (cmd_q == CMD_WRITE) state_d = S_WR_DATA;
          else                        state_d = S_RD_REQ;
        end
      end
      S_WR_DATA: begin
        if (in_fire) state_d = S_WR_REQ;
      end
      S_WR_REQ: begin
        if ((~awvalid_q | axi_awready_i) &&
            (~wvalid_q | axi_wready_i))
          state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (axi_bvalid_i) state_d = last ? S_STATUS : S_WR_DATA;
      end
      S_RD_REQ: begin
        if (axi_arready_i) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (r_fire) state_d = last ? S_STATUS : S_RD_REQ;
      end
      S_STATUS: begin
        if (st_sent_q && outport_accept_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; host accept is registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      accept_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      accept_q <= (state_d == S_IDLE) | (state_d == S_ADDR)
                | (state_d == S_WR_DATA);
    end
  end

  // Command context, AXI request registers and output holding register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmd_q       <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      out_valid_q <= 1'b0;
      st_sent_q   <= 1'b0;
    end else begin
      if (out_valid_q && outport_accept_i) out_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (in_fire) begin
            cmd_q     <= inport_data_i[7:0];
            len_q     <= inport_data_i[31:16];
            cnt_q     <= '0;
            err_q     <= 1'b0;
            st_sent_q <= 1'b0;
          end
        end
        S_ADDR: begin
          if (in_fire) begin
            addr_q <= {inport_data_i[31:2], 2'b00};
            if (len_q == 16'd0) begin
              out_valid_q <= 1'b1;
              out_data_q  <= status_word(cmd_q, 1'b0, 16'd0);
              st_sent_q   <= 1'b1;
            end
          end
        end
        S_WR_DATA: begin
          if (in_fire) begin
            wdata_q   <= inport_data_i;
            awvalid_q <= 1'b1;
            wvalid_q  <= 1'b1;
          end
        end
        S_WR_REQ: begin
          if (axi_awready_i) awvalid_q <= 1'b0;
          if (axi_wready_i)  wvalid_q  <= 1'b0;
        end
        S_WR_RESP: begin
          if (axi_bvalid_i) begin
            cnt_q  <= cnt_q + 16'd1;
            addr_q <= addr_q + 32'd4;
            err_q  <= err_q | b_err;
            if (last) begin
              out_valid_q <= 1'b1;
              out_data_q  <= status_word(cmd_q, err_q | b_err,
                                         cnt_q + 16'd1);
              st_sent_q   <= 1'b1;
            end
          end
        end
        S_RD_RESP: begin
          if (r_fire) begin
            out_valid_q <= 1'b1;
            out_data_q  <= axi_rdata_i;
            cnt_q       <= cnt_q + 16'd1;
            addr_q      <= addr_q + 32'd4;
            err_q       <= err_q | r_err;
          end
        end
        S_STATUS: begin
          if (!st_sent_q && out_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= status_word(cmd_q, err_q, cnt_q);
            st_sent_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ft60x_axi_cmd.sv
// Self-checking bench for ft60x_axi_cmd: random host/AXI
// timing against a command-level reference model.
module tb_ft60x_axi_cmd;

  logic        clk_i;
  logic        rst_i;
  logic        inport_valid_i;
  logic [31:0] inport_data_i;
  logic        inport_accept_o;
  logic        outport_valid_o;
  logic [31:0] outport_data_o;
  logic        outport_accept_i;
  logic        axi_awvalid_o;
  logic [31:0] axi_awaddr_o;
  logic        axi_awready_i;
  logic        axi_wvalid_o;
  logic [31:0] axi_wdata_o;
  logic [3:0]  axi_wstrb_o;
  logic        axi_wready_i;
  logic        axi_bvalid_i;
  logic [1:0]  axi_bresp_i;
  logic        axi_bready_o;
  logic        axi_arvalid_o;
  logic [31:0] axi_araddr_o;
  logic        axi_arready_i;
  logic        axi_rvalid_i;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic        axi_rready_o;

  ft60x_axi_cmd dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .inport_valid_i   (inport_valid_i),
    .inport_data_i    (inport_data_i),
    .inport_accept_o  (inport_accept_o),
    .outport_valid_o  (outport_valid_o),
    .outport_data_o   (outport_data_o),
    .outport_accept_i (outport_accept_i),
    .axi_awvalid_o    (axi_awvalid_o),
    .axi_awaddr_o     (axi_awaddr_o),
    .axi_awready_i    (axi_awready_i),
    .axi_wvalid_o     (axi_wvalid_o),
    .axi_wdata_o      (axi_wdata_o),
    .axi_wstrb_o      (axi_wstrb_o),
    .axi_wready_i     (axi_wready_i),
    .axi_bvalid_i     (axi_bvalid_i),
    .axi_bresp_i      (axi_bresp_i),
    .axi_bready_o     (axi_bready_o),
    .axi_arvalid_o    (axi_arvalid_o),
    .axi_araddr_o     (axi_araddr_o),
    .axi_arready_i    (axi_arready_i),
    .axi_rvalid_i     (axi_rvalid_i),
    .axi_rdata_i      (axi_rdata_i),
    .axi_rresp_i      (axi_rresp_i),
    .axi_rready_o     (axi_rready_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks = 0;
  int errors = 0;

  // Environment knobs
  int host_pct = 100;
  int acc_pct  = 100;
  int ar_pct   = 100;
  int b_pct    = 100;
  int r_pct    = 100;
  int aw_dly   = 0;
  int w_dly    = 0;
  bit b_hold   = 0;
  logic [31:0] err_addr = 32'h1;

  // Environment state and logs
  logic [31:0] host_q[$];
  logic [31:0] aw_log[$], w_log[$], ar_log[$], out_log[$];
  logic [31:0] aw_pair[$], w_pair[$];
  logic [1:0]  b_resp_q[$];
  logic [31:0] r_data_q[$];
  logic [1:0]  r_resp_q[$];
  logic [31:0] slv_mem[logic [31:0]];
  int viol = 0;
  int ost_aw = 0;
  int ost_ar = 0;
  int aw_wait = 0;
  int w_wait = 0;
  bit f_h, f_aw, f_w, f_b, f_ar, f_r, f_o;
  bit hold_o;
  logic [31:0] hold_d;

  // Reference model state
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] exp_out[$], exp_aw[$], exp_w[$], exp_ar[$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic bit pct(input int p);
    return $urandom_range(1, 100) <= p;
  endfunction

  // Host source, AXI slave and response sink
  initial begin
    inport_valid_i   = 1'b0;
    inport_data_i    = '0;
    outport_accept_i = 1'b0;
    axi_awready_i    = 1'b0;
    axi_wready_i     = 1'b0;
    axi_bvalid_i     = 1'b0;
    axi_bresp_i      = 2'b00;
    axi_arready_i    = 1'b0;
    axi_rvalid_i     = 1'b0;
    axi_rdata_i      = '0;
    axi_rresp_i      = 2'b00;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        axi_awready_i = 0; axi_wready_i = 0;
        axi_bvalid_i = 0; axi_arready_i = 0;
        axi_rvalid_i = 0; outport_accept_i = 0;
        {f_h, f_aw, f_w, f_b, f_ar, f_r, f_o} = '0;
        hold_o = 0; aw_wait = 0; w_wait = 0;
        ost_aw = 0; ost_ar = 0;
        b_resp_q.delete(); r_data_q.delete();
        r_resp_q.delete(); aw_pair.delete();
        w_pair.delete();
        continue;
      end
      if (f_h) begin
        void'(host_q.pop_front());
        inport_valid_i = 0;
      end
      if (f_b) begin
        void'(b_resp_q.pop_front());
        axi_bvalid_i = 0;
      end
      if (f_r) begin
        void'(r_data_q.pop_front());
        void'(r_resp_q.pop_front());
        axi_rvalid_i = 0;
      end
      if (f_aw) aw_wait = 0;
      if (f_w) w_wait = 0;
      if (!inport_valid_i && host_q.size() > 0 && pct(host_pct)) begin
        inport_valid_i = 1;
        inport_data_i  = host_q[0];
      end
      axi_awready_i = (aw_dly < 0) ? pct(50) : (aw_wait >= aw_dly);
      axi_wready_i  = (w_dly < 0) ? pct(50) : (w_wait >= w_dly);
      if (!axi_bvalid_i && b_resp_q.size() > 0 && !b_hold && pct(b_pct)) begin
        axi_bvalid_i = 1;
        axi_bresp_i  = b_resp_q[0];
      end
      axi_arready_i = pct(ar_pct);
      if (!axi_rvalid_i && r_data_q.size() > 0 && pct(r_pct)) begin
        axi_rvalid_i = 1;
        axi_rdata_i  = r_data_q[0];
        axi_rresp_i  = r_resp_q[0];
      end
      outport_accept_i = pct(acc_pct);
      #1;
      if (hold_o && !(outport_valid_o && outport_data_o === hold_d)) viol++;
      f_h  = inport_valid_i && inport_accept_o;
      f_aw = axi_awvalid_o && axi_awready_i;
      f_w  = axi_wvalid_o && axi_wready_i;
      f_b  = axi_bvalid_i && axi_bready_o;
      f_ar = axi_arvalid_o && axi_arready_i;
      f_r  = axi_rvalid_i && axi_rready_o;
      f_o  = outport_valid_o && outport_accept_i;
      hold_o = outport_valid_o && !outport_accept_i;
      hold_d = outport_data_o;
      if (axi_awvalid_o && !f_aw) aw_wait++;
      if (axi_wvalid_o && !f_w) w_wait++;
      if (f_aw) begin
        if (ost_aw != 0 || axi_awaddr_o[1:0] != 2'b00) viol++;
        ost_aw++;
        aw_log.push_back(axi_awaddr_o);
        aw_pair.push_back(axi_awaddr_o);
      end
      if (f_w) begin
        if (axi_wstrb_o !== 4'hF) viol++;
        w_log.push_back(axi_wdata_o);
        w_pair.push_back(axi_wdata_o);
      end
      while (aw_pair.size() > 0 && w_pair.size() > 0) begin
        logic [31:0] a;
        a = aw_pair.pop_front();
        slv_mem[a] = w_pair.pop_front();
        b_resp_q.push_back(a == err_addr ? 2'b10 : 2'b00);
      end
      if (f_b) ost_aw--;
      if (f_ar) begin
        if (ost_ar != 0 || axi_araddr_o[1:0] != 2'b00) viol++;
        ost_ar++;
        ar_log.push_back(axi_araddr_o);
        r_data_q.push_back(slv_mem.exists(axi_araddr_o) ?
                           slv_mem[axi_araddr_o] : dflt(axi_araddr_o));
        r_resp_q.push_back(axi_araddr_o == err_addr ? 2'b10 : 2'b00);
      end
      if (f_r) ost_ar--;
      if (f_o) out_log.push_back(outport_data_o);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: host words produced and effects expected for one command.
  task automatic send_cmd(input logic [7:0] cmd, input int len,
                          input logic [31:0] a_word,
                          input logic [31:0] data[$]);
    logic [31:0] a;
    bit err;
    host_q.push_back({16'(len), 8'h00, cmd});
    host_q.push_back(a_word);
    a = a_word & ~32'h3;
    err = 0;
    for (int i = 0; i < len; i++) begin
      if (cmd == 8'h10) begin
        host_q.push_back(data[i]);
        exp_aw.push_back(a);
        exp_w.push_back(data[i]);
        ref_mem[a] = data[i];
      end else begin
        exp_ar.push_back(a);
        exp_out.push_back(ref_mem.exists(a) ? ref_mem[a] : dflt(a));
      end
      if (a == err_addr) err = 1;
      a = a + 32'd4;
    end
    exp_out.push_back({16'(len), 7'd0, err, cmd});
  endtask

  task automatic finish_cmd(input string tag, output logic [31:0] last);
    int n;
    logic [31:0] o;
    n = exp_out.size();
    for (int c = 0; c < 3000 && out_log.size() < n; c++) @(negedge clk_i);
    repeat (8) @(negedge clk_i);
    chk({tag, " out count"}, 32'(out_log.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      o = (i < out_log.size()) ? out_log[i] : 32'hx;
      chk($sformatf("%s out[%0d]", tag, i), o, exp_out[i]);
    end
    chk({tag, " aw count"}, 32'(aw_log.size()), 32'(exp_aw.size()));
    for (int i = 0; i < exp_aw.size() && i < aw_log.size(); i++)
      chk($sformatf("%s aw[%0d]", tag, i), aw_log[i], exp_aw[i]);
    chk({tag, " w count"}, 32'(w_log.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < w_log.size(); i++)
      chk($sformatf("%s w[%0d]", tag, i), w_log[i], exp_w[i]);
    chk({tag, " ar count"}, 32'(ar_log.size()), 32'(exp_ar.size()));
    for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++)
      chk($sformatf("%s ar[%0d]", tag, i), ar_log[i], exp_ar[i]);
    chk({tag, " protocol"}, 32'(viol), 32'd0);
    last = (out_log.size() > 0) ? out_log[out_log.size()-1] : 32'hx;
    out_log.delete(); aw_log.delete(); w_log.delete(); ar_log.delete();
    exp_out.delete(); exp_aw.delete(); exp_w.delete(); exp_ar.delete();
    viol = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " accept"}, 32'(inport_accept_o), 32'd0);
    chk({tag, " ovalid"}, 32'(outport_valid_o), 32'd0);
    chk({tag, " odata"}, outport_data_o, 32'd0);
    chk({tag, " awvalid"}, 32'(axi_awvalid_o), 32'd0);
    chk({tag, " wvalid"}, 32'(axi_wvalid_o), 32'd0);
    chk({tag, " arvalid"}, 32'(axi_arvalid_o), 32'd0);
    chk({tag, " bready"}, 32'(axi_bready_o), 32'd0);
    chk({tag, " rready"}, 32'(axi_rready_o), 32'd0);
    chk({tag, " awaddr"}, axi_awaddr_o, 32'd0);
    chk({tag, " araddr"}, axi_araddr_o, 32'd0);
    chk({tag, " wdata"}, axi_wdata_o, 32'd0);
  endtask

  initial begin
    logic [31:0] d[$];
    logic [31:0] last;
    logic [31:0] a;
    int len;
    int c;

    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1 chk_reset_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Write len=2, everything ready
    d = '{32'hA, 32'hB};
    send_cmd(8'h10, 2, 32'h1000, d);
    finish_cmd("wr2", last);
    chk("wr2 status", last, 32'h0002_0010);

    // Read len=3 of preloaded 1,2,3 with a 50% sink
    for (int i = 0; i < 3; i++) begin
      slv_mem[32'h2000 + 32'(4*i)] = 32'(i + 1);
      ref_mem[32'h2000 + 32'(4*i)] = 32'(i + 1);
    end
    acc_pct = 50;
    d.delete();
    send_cmd(8'h11, 3, 32'h2000, d);
    finish_cmd("rd3", last);
    chk("rd3 status", last, 32'h0003_0011);
    acc_pct = 100;

    // AW/W handshake orderings
    aw_dly = 0; w_dly = 3;
    d = '{32'hC0DE_0001};
    send_cmd(8'h10, 1, 32'h4000, d);
    finish_cmd("aw_first", last);
    aw_dly = 3; w_dly = 0;
    d = '{32'hC0DE_0002};
    send_cmd(8'h10, 1, 32'h4004, d);
    finish_cmd("w_first", last);
    aw_dly = 0; w_dly = 0;
    d = '{32'hC0DE_0003};
    send_cmd(8'h10, 1, 32'h4008, d);
    finish_cmd("aw_w_same", last);
    chk("aw_w_same status", last, 32'h0001_0010);

    // Read with an error response on the second beat
    err_addr = 32'h2004;
    d.delete();
    send_cmd(8'h11, 2, 32'h2000, d);
    finish_cmd("rd_err", last);
    chk("rd_err status", last, 32'h0002_0111);
    err_addr = 32'h1;

    // Unknown header dropped, then zero-length read
    host_q.push_back(32'h0001_0055);
    d.delete();
    send_cmd(8'h11, 0, 32'h5000, d);
    finish_cmd("bad_hdr", last);
    chk("bad_hdr status", last, 32'h0000_0011);

    // Address wrap, with unaligned address word
    d = '{32'h1234_5678, 32'h9ABC_DEF0};
    send_cmd(8'h10, 2, 32'hFFFF_FFFF, d);
    finish_cmd("wrap", last);

    // Reset while waiting for a write response
    b_hold = 1;
    host_q.push_back(32'h0002_0010);
    host_q.push_back(32'h0000_3000);
    host_q.push_back(32'h1111_1111);
    host_q.push_back(32'h0000_00BB);
    for (c = 0; c < 200 && axi_bready_o !== 1'b1; c++) @(negedge clk_i);
    chk("rst wait bready", 32'(axi_bready_o), 32'd1);
    #3 rst_i = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(negedge clk_i);
    #3 rst_i = 1'b0;
    b_hold = 0;
    chk("midrst aw count", 32'(aw_log.size()), 32'd1);
    a = (aw_log.size() > 0) ? aw_log[0] : 32'hx;
    chk("midrst aw addr", a, 32'h3000);
    ref_mem[32'h3000] = 32'h1111_1111;
    aw_log.delete(); w_log.delete(); viol = 0;
    @(negedge clk_i);
    chk("midrst idle accept", 32'(inport_accept_o), 32'd1);
    for (c = 0; c < 200 && host_q.size() > 0; c++) @(negedge clk_i);
    d.delete();
    send_cmd(8'h11, 2, 32'h3000, d);
    finish_cmd("after_rst", last);

    // Randomized commands and timing
    for (int k = 0; k < 25; k++) begin
      host_pct = $urandom_range(30, 100);
      acc_pct  = $urandom_range(30, 100);
      ar_pct   = $urandom_range(30, 100);
      b_pct    = $urandom_range(30, 100);
      r_pct    = $urandom_range(30, 100);
      aw_dly   = -1;
      w_dly    = -1;
      len = $urandom_range(0, 4);
      a = $urandom();
      if (k % 3 == 0) a = 32'h6000 + 32'($urandom_range(0, 15));
      err_addr = ($urandom_range(0, 2) == 0) ?
                 (a & ~32'h3) + 32'(4 * $urandom_range(0, 3)) : 32'h1;
      if ($urandom_range(0, 3) == 0)
        host_q.push_back({16'($urandom()), 8'h00,
                          8'($urandom_range(32, 255))});
      d.delete();
      for (int i = 0; i < len; i++) d.push_back($urandom());
      send_cmd($urandom_range(0, 1) ? 8'h10 : 8'h11, len, a, d);
      finish_cmd($sformatf("rnd%0d", k), last);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
